// File: rtl/sd_clk_div.sv
// Glitch-free programmable SD bus clock divider with edge strobes and safe divider switching.
// Optional flow-control hold of the low phase when SD_CLK_HOLD_EN is defined.
module sd_clk_div #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DIV_INIT = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_ld_i,
  input  logic             hold_i,
  output logic             sd_clk_o,
  output logic             rise_stb_o,
  output logic             fall_stb_o,
  output logic             div_ack_o,
  output logic             running_o
);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             sd_clk_q, sd_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ack_q, ack_d;
  logic             apply;
  logic             hold_stall;

`ifdef SD_CLK_HOLD_EN
  assign hold_stall = hold_i;
`else
  logic unused_hold;
  assign unused_hold = hold_i;
  assign hold_stall  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    sd_clk_d   = sd_clk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    ack_d      = 1'b0;
    apply      = 1'b0;

    if (div_ld_i) begin
      div_pend_d = div_i;
      pend_d     = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        sd_clk_d = 1'b0;
        apply    = 1'b1;
        if (en_i) begin
          state_d = StLo;
          cnt_d   = '0;
        end
      end
      StLo: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (cnt_q != div_cur_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!hold_stall) begin
          state_d  = StHi;
          cnt_d    = '0;
          sd_clk_d = 1'b1;
          rise_d   = 1'b1;
        end
      end
      StHi: begin
        // The high phase always runs to completion; en_i only picks the follow-on state.
        if (cnt_q != div_cur_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          sd_clk_d = 1'b0;
          fall_d   = 1'b1;
          cnt_d    = '0;
          apply    = 1'b1;
          state_d  = en_i ? StLo : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A load coinciding with the apply point bypasses the pending register.
    if (apply) begin
      if (div_ld_i) begin
        div_cur_d = div_i;
        ack_d     = 1'b1;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        div_cur_d = div_pend_q;
        ack_d     = 1'b1;
        pend_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_cur_q  <= DIV_W'(DIV_INIT);
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      sd_clk_q   <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      sd_clk_q   <= sd_clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ack_q      <= ack_d;
    end
  end

  assign sd_clk_o   = sd_clk_q;
  assign rise_stb_o = rise_q;
  assign fall_stb_o = fall_q;
  assign div_ack_o  = ack_q;
  assign running_o  = (state_q != StIdle);

endmodule

// File: tb/tb_sd_clk_div.sv
// Directed bench for sd_clk_div: phase lengths, strobes, divider switching, stop, reset, hold.
module tb_sd_clk_div;

  localparam int LIMIT = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div;
  logic       ld;
  logic       hold;
  logic       sd_clk;
  logic       rise_stb;
  logic       fall_stb;
  logic       div_ack;
  logic       running;

  int n_cmp = 0;
  int n_err = 0;

  sd_clk_div #(
    .DIV_W   (8),
    .DIV_INIT(34)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .div_i     (div),
    .div_ld_i  (ld),
    .hold_i    (hold),
    .sd_clk_o  (sd_clk),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb),
    .div_ack_o (div_ack),
    .running_o (running)
  );

  always #5 clk = ~clk;

  // Counts samples (negedges) at the given level starting with the current one; returns on the
  // first sample at the other level, or after LIMIT samples.
  task automatic measure(input logic level, output int n, output int stb, output int acks);
    n = 0; stb = 0; acks = 0;
    while (sd_clk === level && n < LIMIT) begin
      n++;
      stb  += int'(rise_stb) + int'(fall_stb);
      acks += int'(div_ack);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ld = 1'b0; hold = 1'b0; div = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sd_clk, rise_stb, fall_stb, div_ack, running} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {sd_clk, rise_stb, fall_stb, div_ack, running});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (running !== 1'b0) begin
      n_err++; $display("FAIL idle_running: got %b expected 0", running);
    end
  endtask

  task automatic test_basic();
    int n, s, a;
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({running, sd_clk} !== 2'b10) begin
      n_err++; $display("FAIL start_running: got %b expected 10", {running, sd_clk});
    end
    measure(1'b0, n, s, a);
    n_cmp++;
    if (n !== 35 || s !== 0) begin
      n_err++; $display("FAIL first_low: got len %0d stb %0d expected 35 0", n, s);
    end
    n_cmp++;
    if (rise_stb !== 1'b1) begin
      n_err++; $display("FAIL rise_stb: got %b expected 1", rise_stb);
    end
    measure(1'b1, n, s, a);
    n_cmp++;
    if (n !== 35 || s !== 1) begin
      n_err++; $display("FAIL high_34: got len %0d stb %0d expected 35 1", n, s);
    end
    n_cmp++;
    if (fall_stb !== 1'b1) begin
      n_err++; $display("FAIL fall_stb: got %b expected 1", fall_stb);
    end
    measure(1'b0, n, s, a);
    n_cmp++;
    if (n !== 35 || s !== 1) begin
      n_err++; $display("FAIL low_34: got len %0d stb %0d expected 35 1", n, s);
    end
  endtask

  // Entered at a rise sample with divider 34 active.
  task automatic test_div_change();
    int n, s, a;
    repeat (10) @(negedge clk);
    div = 8'd0; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    measure(1'b1, n, s, a);
    n_cmp++;
    if (n !== 24 || a !== 0) begin
      n_err++; $display("FAIL old_high_kept: got len %0d acks %0d expected 24 0", n, a);
    end
    n_cmp++;
    if ({div_ack, fall_stb} !== 2'b11) begin
      n_err++; $display("FAIL ack_with_fall: got %b expected 11", {div_ack, fall_stb});
    end
    measure(1'b0, n, s, a);
    n_cmp++;
    if (n !== 1 || a !== 1) begin
      n_err++; $display("FAIL div0_low: got len %0d acks %0d expected 1 1", n, a);
    end
    measure(1'b1, n, s, a);
    n_cmp++;
    if (n !== 1 || s !== 1) begin
      n_err++; $display("FAIL div0_high: got len %0d stb %0d expected 1 1", n, s);
    end
    measure(1'b0, n, s, a);
    n_cmp++;
    if (n !== 1 || s !== 1 || a !== 0) begin
      n_err++; $display("FAIL div0_low2: got len %0d stb %0d acks %0d expected 1 1 0", n, s, a);
    end
  endtask

  // Entered at a rise sample with divider 0 active.
  task automatic test_reset_mid();
    int n, s, a;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sd_clk, rise_stb, fall_stb, div_ack, running} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_high: got %b expected 00000",
               {sd_clk, rise_stb, fall_stb, div_ack, running});
    end
    rst = 1'b0;
    @(negedge clk);
    measure(1'b0, n, s, a);
    n_cmp++;
    if (n !== 35) begin
      n_err++; $display("FAIL div_restored: got low %0d expected 35", n);
    end
  endtask

  // Entered at a rise sample with divider 34 active.
  task automatic test_stop();
    int n, s, a, act;
    repeat (5) @(negedge clk);
    en = 1'b0;
    measure(1'b1, n, s, a);
    n_cmp++;
    if (n !== 30) begin
      n_err++; $display("FAIL stop_full_high: got remaining %0d expected 30", n);
    end
    n_cmp++;
    if (fall_stb !== 1'b1) begin
      n_err++; $display("FAIL stop_fall_stb: got %b expected 1", fall_stb);
    end
    @(negedge clk);
    n_cmp++;
    if ({sd_clk, fall_stb, running} !== 3'b000) begin
      n_err++; $display("FAIL parked: got %b expected 000", {sd_clk, fall_stb, running});
    end
    act = 0;
    repeat (10) begin
      @(negedge clk);
      act += int'(sd_clk) + int'(rise_stb) + int'(fall_stb);
    end
    n_cmp++;
    if (act !== 0) begin
      n_err++; $display("FAIL idle_quiet: got activity %0d expected 0", act);
    end
    div = 8'd19; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    n_cmp++;
    if (div_ack !== 1'b1) begin
      n_err++; $display("FAIL idle_ack: got %b expected 1", div_ack);
    end
    @(negedge clk);
    n_cmp++;
    if (div_ack !== 1'b0) begin
      n_err++; $display("FAIL idle_ack_pulse: got %b expected 0", div_ack);
    end
  endtask

  // Entered idle with divider 19 active.
  task automatic test_load_twice();
    int n, s, a;
    en = 1'b1;
    @(negedge clk);
    measure(1'b0, n, s, a);
    n_cmp++;
    if (n !== 20) begin
      n_err++; $display("FAIL low_19: got %0d expected 20", n);
    end
    repeat (3) @(negedge clk);
    div = 8'd4; ld = 1'b1;
    @(negedge clk);
    div = 8'd9;
    @(negedge clk);
    ld = 1'b0;
    measure(1'b1, n, s, a);
    n_cmp++;
    if (n !== 15 || a !== 0) begin
      n_err++; $display("FAIL high_19: got len %0d acks %0d expected 15 0", n, a);
    end
    measure(1'b0, n, s, a);
    n_cmp++;
    if (n !== 10 || a !== 1) begin
      n_err++; $display("FAIL low_9_one_ack: got len %0d acks %0d expected 10 1", n, a);
    end
    measure(1'b1, n, s, a);
    n_cmp++;
    if (n !== 10 || a !== 0) begin
      n_err++; $display("FAIL high_9: got len %0d acks %0d expected 10 0", n, a);
    end
  endtask

  // Entered at a fall sample with divider 9 active.
  task automatic test_hold();
    int n, s, a;
    fork
      measure(1'b0, n, s, a);
      begin
        repeat (9) @(negedge clk);
        hold = 1'b1;
        repeat (20) @(negedge clk);
        hold = 1'b0;
      end
    join
`ifdef SD_CLK_HOLD_EN
    n_cmp++;
    if (n !== 30 || s !== 1) begin
      n_err++; $display("FAIL hold_low: got len %0d stb %0d expected 30 1", n, s);
    end
`else
    n_cmp++;
    if (n !== 10 || s !== 1) begin
      n_err++; $display("FAIL hold_ignored: got len %0d stb %0d expected 10 1", n, s);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_change();
    test_reset_mid();
    test_stop();
    test_load_twice();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
